acia6850_fifo: RTL

- 6850-compatible serial port (ACIA) that sits directly downstream of the Altair CPU/bus-decode top level.
- Consumes the decoded SIO read/write strobes, addr[0] and the CPU data bus.
- Returns status or RX data to the CPU read mux and drives the external tx/rx serial pins, 8N1.
- Differs from a bare ACIA by buffering received bytes in a small RX FIFO, so console input is not lost while the 4K BASIC interpreter is busy.

---
 rtl/acia_pkg.sv | 23 ++
 rtl/acia_rx_fifo.sv | 59 +++++
 rtl/acia6850_fifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acia_pkg.sv
// Shared definitions for the 6850-style ACIA: status bit positions, the
// control-register master-reset code and the serializer state type.
package acia_pkg;

  localparam int unsigned STAT_RDRF = 0;
  localparam int unsigned STAT_TDRE = 1;
  localparam int unsigned STAT_DCD  = 2;
  localparam int unsigned STAT_CTS  = 3;
  localparam int unsigned STAT_FE   = 4;
  localparam int unsigned STAT_OVRN = 5;
  localparam int unsigned STAT_PE   = 6;
  localparam int unsigned STAT_IRQ  = 7;

  localparam logic [1:0] CR_MASTER_RESET = 2'b11;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

endpackage

// File: rtl/acia_rx_fifo.sv
// Receive FIFO for the ACIA: synchronous push/pop, combinational head,
// pointers wrap modulo the depth, flush clears pointers and count.
module acia_rx_fifo
  import acia_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];
  assign rdata = mem[rd_ptr];

  // A pop on the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acia6850_fifo.sv
// 6850-compatible ACIA, fixed 8N1, with a buffered receive path.
// Optional ACIA_TXIRQ_EN: CR[6:5]=2'b01 additionally raises irq on TDRE.
module acia6850_fifo
  import acia_pkg::*;
#(
  parameter int unsigned BAUD_DIV        = 52,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       addr,
  input  logic [7:0] data_in,
  input  logic       rd,
  input  logic       we,
  output logic [7:0] data_out,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  logic rd_q, we_q;
  logic rd_pulse, we_pulse;
  logic ctrl_wr, data_wr, data_rd, master_rst;

  logic [7:0] ctrl;
  logic [7:0] thr;
  logic       tdre;
  logic       fe, ovrn;
  logic       irq_q, irq_cond;
  logic [7:0] last_rd;
  logic [7:0] status;

  ser_state_e tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shr;
  logic        tx_tick, tx_load;

  ser_state_e rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shr;
  logic        rx_fall, rx_half, rx_tick;
  logic        rx_push_req, rx_frame_err;

  logic [7:0]               fifo_head;
  logic                     fifo_full, fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     ctrl_unused;

  assign ctrl_unused = ^{ctrl[6:0], fifo_count};

  assign rd_pulse   = rd & ~rd_q;
  assign we_pulse   = we & ~we_q;
  assign ctrl_wr    = we_pulse & ~addr;
  assign data_wr    = we_pulse & addr;
  assign data_rd    = rd_pulse & addr;
  assign master_rst = ctrl_wr & (data_in[1:0] == CR_MASTER_RESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b0;
      we_q <= 1'b0;
      ctrl <= '0;
    end else begin
      rd_q <= rd;
      we_q <= we;
      if (ctrl_wr) ctrl <= data_in;
    end
  end

  // ---------------- transmitter ----------------
  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_load = (tx_state == SER_IDLE) & ~tdre & ~master_rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= SER_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    if (master_rst) begin
      tx_next = SER_IDLE;
    end else begin
      unique case (tx_state)
        SER_IDLE:  if (!tdre) tx_next = SER_START;
        SER_START: if (tx_tick) tx_next = SER_DATA;
        SER_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = SER_STOP;
        SER_STOP:  if (tx_tick) tx_next = SER_IDLE;
        default:   tx_next = SER_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (tx_state)
      SER_START: tx = 1'b0;
      SER_DATA:  tx = tx_shr[0];
      default:   tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shr <= '0;
    end else begin
      if (tx_state == SER_IDLE || tx_tick || master_rst) tx_cnt <= '0;
      else                                                tx_cnt <= tx_cnt + 16'd1;
      if (tx_load) begin
        tx_shr <= thr;
        tx_bit <= '0;
      end else if (tx_state == SER_DATA && tx_tick) begin
        tx_shr <= {1'b1, tx_shr[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // Holding register empties the moment the shifter takes the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr  <= '0;
      tdre <= 1'b1;
    end else if (master_rst) begin
      tdre <= 1'b1;
    end else if (data_wr && tdre) begin
      thr  <= data_in;
      tdre <= 1'b0;
    end else if (tx_load) begin
      tdre <= 1'b1;
    end
  end

  // ---------------- receiver ----------------
  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_half = (rx_cnt == HALF_LAST);
  assign rx_tick = (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= SER_IDLE;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_next;
    end
  end

  // After a framing error the line must go high again before a new
  // falling edge can be seen, which gives the wait-for-idle behaviour.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      SER_IDLE:  if (rx_fall) rx_next = SER_START;
      SER_START: if (rx_half) rx_next = rx_s2 ? SER_IDLE : SER_DATA;
      SER_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = SER_STOP;
      SER_STOP:  if (rx_tick) rx_next = SER_IDLE;
      default:   rx_next = SER_IDLE;
    endcase
  end

  always_comb begin
    rx_push_req  = 1'b0;
    rx_frame_err = 1'b0;
    if (rx_state == SER_STOP && rx_tick) begin
      rx_push_req  = rx_s2;
      rx_frame_err = ~rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shr <= '0;
    end else begin
      if (rx_state == SER_IDLE || rx_next != rx_state || rx_tick) rx_cnt <= '0;
      else                                                        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == SER_START) begin
        rx_bit <= '0;
      end else if (rx_state == SER_DATA && rx_tick) begin
        rx_shr <= {rx_s2, rx_shr[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end

  acia_rx_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (master_rst),
    .push  (rx_push_req),
    .pop   (data_rd),
    .wdata (rx_shr),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- flags, irq, read mux ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe      <= 1'b0;
      ovrn    <= 1'b0;
      last_rd <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= irq_cond;
      if (data_rd && !fifo_empty) last_rd <= fifo_head;
      if (master_rst) begin
        fe   <= 1'b0;
        ovrn <= 1'b0;
      end else begin
        if (rx_frame_err) fe <= 1'b1;
        else if (data_rd) fe <= 1'b0;
        if (rx_push_req && fifo_full && !data_rd) ovrn <= 1'b1;
        else if (data_rd)                         ovrn <= 1'b0;
      end
    end
  end

  always_comb begin
`ifdef ACIA_TXIRQ_EN
    irq_cond = (ctrl[7] & ~fifo_empty) | ((ctrl[6:5] == 2'b01) & tdre);
`else
    irq_cond = ctrl[7] & ~fifo_empty;
`endif
  end

  assign irq = irq_q;

  always_comb begin
    status            = '0;
    status[STAT_RDRF] = ~fifo_empty;
    status[STAT_TDRE] = tdre;
    status[STAT_FE]   = fe;
    status[STAT_OVRN] = ovrn;
    status[STAT_IRQ]  = irq_q;
  end

  always_comb begin
    if (!addr)           data_out = status;
    else if (fifo_empty) data_out = last_rd;
    else                 data_out = fifo_head;
  end

endmodule
